// File: rtl/mig_ui_pkg.sv
// Shared constants and types for the MIG user-interface block-RAM responder.
package mig_ui_pkg;

    localparam int DEF_ADDR_W = 29;
    localparam int DEF_DATA_W = 256;
    localparam int DEF_MASK_W = 32;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    typedef enum logic [1:0] {
        DISP_NONE    = 2'd0,
        DISP_WRITE   = 2'd1,
        DISP_READ    = 2'd2,
        DISP_INVALID = 2'd3
    } disp_e;

endpackage

// File: rtl/ui_sync_fifo.sv
// Small synchronous FIFO with a registered occupancy count; used for the command and write-data queues.
module ui_sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             srst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  do_push_s, do_pop_s;

    assign full  = (count_q == (DEPTH_LOG2+1)'(DEPTH));
    assign empty = (count_q == (DEPTH_LOG2+1)'(0));
    assign dout  = mem_q[rd_ptr_q];

    // Pointer and count update; push on full / pop on empty are ignored.
    always_comb begin
        do_push_s = push && !full;
        do_pop_s  = pop && !empty;
        wr_ptr_d  = do_push_s ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
        rd_ptr_d  = do_pop_s  ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + (DEPTH_LOG2+1)'(1);
            2'b01:   count_d = count_q - (DEPTH_LOG2+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state with async and soft reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while empty so it carries no reset.
    always_ff @(posedge clk) begin
        if (do_push_s && !srst) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/mig_app_responder.sv
// Block-RAM stand-in for the MIG 7-series app_* interface: calibration delay, command/data
// pairing through two small queues, in-order fixed-latency reads and optional app_rdy throttling.
module mig_app_responder
    import mig_ui_pkg::*;
#(
    parameter int ADDR_W          = DEF_ADDR_W,
    parameter int DATA_W          = DEF_DATA_W,
    parameter int MASK_W          = DEF_MASK_W,
    parameter int DEPTH_LOG2      = 6,
    parameter int RD_LAT          = 4,
    parameter int CALIB_CYCLES    = 16,
    parameter int THROTTLE_PERIOD = 0
) (
    input  logic              ui_clk,
    input  logic              sys_rst,
    output logic              ui_clk_sync_rst,
    output logic              init_calib_complete,
    input  logic [ADDR_W-1:0] app_addr,
    input  logic [2:0]        app_cmd,
    input  logic              app_en,
    output logic              app_rdy,
    input  logic [DATA_W-1:0] app_wdf_data,
    input  logic              app_wdf_wren,
    input  logic              app_wdf_end,
    input  logic [MASK_W-1:0] app_wdf_mask,
    output logic              app_wdf_rdy,
    output logic [DATA_W-1:0] app_rd_data,
    output logic              app_rd_data_valid,
    output logic              app_rd_data_end,
    output logic              err_cmd
);
    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam int CMDQ_W = 3 + DEPTH_LOG2;
    localparam int WDFQ_W = DATA_W + MASK_W;
    localparam int CAL_W  = $clog2(CALIB_CYCLES + 1);
    localparam int THR_W  = (THROTTLE_PERIOD > 1) ? $clog2(THROTTLE_PERIOD) : 1;

    logic                  rst_meta_q, rst_sync_q;
    logic [CAL_W-1:0]      cal_cnt_q, cal_cnt_d;
    logic                  calib_q, calib_d;
    logic [THR_W-1:0]      thr_q, thr_d;
    logic                  err_q, err_d;
    logic [RD_LAT:0]       vld_q, vld_d;
    logic [DATA_W-1:0]     pipe_q [RD_LAT];
    logic [DATA_W-1:0]     pipe_d [RD_LAT];
    logic [DATA_W-1:0]     ram_q [DEPTH];
    logic [DATA_W-1:0]     ram_rd_q;

    logic                  throttle_slot_s, cmd_push_s, wdf_push_s;
    logic                  cmd_full_s, cmd_empty_s, wdf_full_s, wdf_empty_s;
    logic [CMDQ_W-1:0]     cmd_dout_s;
    logic [WDFQ_W-1:0]     wdf_dout_s;
    logic [2:0]            head_cmd_s;
    logic [DEPTH_LOG2-1:0] head_idx_s;
    logic [DATA_W-1:0]     wr_data_s;
    logic [MASK_W-1:0]     wr_mask_s;
    disp_e                 disp_s;
    logic                  unused_addr_s;

    assign unused_addr_s = ^{app_addr[ADDR_W-1:DEPTH_LOG2+3], app_addr[2:0]};

    // Two-flop reset synchroniser producing the user-side reset.
    always_ff @(posedge ui_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= 1'b1;
        end else begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= rst_meta_q;
        end
    end

    assign ui_clk_sync_rst     = rst_sync_q;
    assign init_calib_complete = calib_q;
    assign err_cmd             = err_q;
    assign app_rd_data_valid   = vld_q[RD_LAT];
    assign app_rd_data_end     = vld_q[RD_LAT];
    assign app_rd_data         = pipe_q[RD_LAT-1];

    assign throttle_slot_s = (THROTTLE_PERIOD != 0) && (thr_q == THR_W'(0));
    assign app_rdy         = calib_q && !cmd_full_s && !throttle_slot_s;
    assign app_wdf_rdy     = calib_q && !wdf_full_s;
    assign cmd_push_s      = app_en && app_rdy;
    assign wdf_push_s      = app_wdf_wren && app_wdf_rdy;

    ui_sync_fifo #(.WIDTH(CMDQ_W), .DEPTH_LOG2(2)) u_cmdq (
        .clk   (ui_clk),
        .rst_n (sys_rst),
        .srst  (rst_sync_q),
        .push  (cmd_push_s),
        .din   ({app_cmd, app_addr[DEPTH_LOG2+2:3]}),
        .pop   (disp_s != DISP_NONE),
        .dout  (cmd_dout_s),
        .full  (cmd_full_s),
        .empty (cmd_empty_s)
    );

    ui_sync_fifo #(.WIDTH(WDFQ_W), .DEPTH_LOG2(2)) u_wdfq (
        .clk   (ui_clk),
        .rst_n (sys_rst),
        .srst  (rst_sync_q),
        .push  (wdf_push_s),
        .din   ({app_wdf_mask, app_wdf_data}),
        .pop   (disp_s == DISP_WRITE),
        .dout  (wdf_dout_s),
        .full  (wdf_full_s),
        .empty (wdf_empty_s)
    );

    assign head_cmd_s = cmd_dout_s[CMDQ_W-1 -: 3];
    assign head_idx_s = cmd_dout_s[DEPTH_LOG2-1:0];
    assign wr_data_s  = wdf_dout_s[DATA_W-1:0];
    assign wr_mask_s  = wdf_dout_s[WDFQ_W-1 -: MASK_W];

    // In-order dispatch: a write at the head waits for its data and blocks everything behind it.
    always_comb begin
        disp_s = DISP_NONE;
        if (!cmd_empty_s) begin
            case (head_cmd_s)
                CMD_WRITE: disp_s = wdf_empty_s ? DISP_NONE : DISP_WRITE;
                CMD_READ:  disp_s = DISP_READ;
                default:   disp_s = DISP_INVALID;
            endcase
        end else begin
            disp_s = DISP_NONE;
        end
    end

    // Next-state for calibration, throttle slot, error flag and the read pipe.
    always_comb begin
        cal_cnt_d = cal_cnt_q;
        calib_d   = calib_q;
        if (!calib_q) begin
            if (cal_cnt_q == CAL_W'(CALIB_CYCLES - 1)) begin
                calib_d = 1'b1;
            end else begin
                cal_cnt_d = cal_cnt_q + CAL_W'(1);
            end
        end else begin
            cal_cnt_d = cal_cnt_q;
        end

        if (THROTTLE_PERIOD == 0 || thr_q == THR_W'(THROTTLE_PERIOD - 1)) begin
            thr_d = THR_W'(0);
        end else begin
            thr_d = thr_q + THR_W'(1);
        end

        err_d = err_q
              | (cmd_push_s && (app_cmd != CMD_WRITE) && (app_cmd != CMD_READ))
              | (app_wdf_end != app_wdf_wren);

        vld_d     = {vld_q[RD_LAT-1:0], disp_s == DISP_READ};
        pipe_d[0] = ram_rd_q;
        for (int k = 1; k < RD_LAT; k++) begin
            pipe_d[k] = pipe_q[k-1];
        end
    end

    // Control and read-pipe registers; the user-side reset flushes everything.
    always_ff @(posedge ui_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            cal_cnt_q <= '0;
            calib_q   <= 1'b0;
            thr_q     <= '0;
            err_q     <= 1'b0;
            vld_q     <= '0;
            for (int k = 0; k < RD_LAT; k++) pipe_q[k] <= '0;
        end else if (rst_sync_q) begin
            cal_cnt_q <= '0;
            calib_q   <= 1'b0;
            thr_q     <= '0;
            err_q     <= 1'b0;
            vld_q     <= '0;
            for (int k = 0; k < RD_LAT; k++) pipe_q[k] <= '0;
        end else begin
            cal_cnt_q <= cal_cnt_d;
            calib_q   <= calib_d;
            thr_q     <= thr_d;
            err_q     <= err_d;
            vld_q     <= vld_d;
            for (int k = 0; k < RD_LAT; k++) pipe_q[k] <= pipe_d[k];
        end
    end

    // Byte-enable block RAM with registered read; contents survive reset.
    always_ff @(posedge ui_clk) begin
        if (disp_s == DISP_WRITE) begin
            for (int b = 0; b < MASK_W; b++) begin
                if (!wr_mask_s[b]) ram_q[head_idx_s][b*8 +: 8] <= wr_data_s[b*8 +: 8];
            end
        end
        ram_rd_q <= ram_q[head_idx_s];
    end

endmodule

// File: tb/tb_mig_app_responder.sv
// Directed, table-driven bench for mig_app_responder (throttle period 3 throughout).
module tb_mig_app_responder;
    localparam int ADDR_W = 29;
    localparam int DATA_W = 256;
    localparam int MASK_W = 32;

    logic              clk = 1'b0;
    logic              sys_rst;
    logic              ui_clk_sync_rst, init_calib_complete;
    logic [ADDR_W-1:0] app_addr;
    logic [2:0]        app_cmd;
    logic              app_en, app_rdy;
    logic [DATA_W-1:0] app_wdf_data;
    logic              app_wdf_wren, app_wdf_end, app_wdf_rdy;
    logic [MASK_W-1:0] app_wdf_mask;
    logic [DATA_W-1:0] app_rd_data;
    logic              app_rd_data_valid, app_rd_data_end, err_cmd;

    always #5 clk = ~clk;

    mig_app_responder #(.THROTTLE_PERIOD(3)) dut (
        .ui_clk              (clk),
        .sys_rst             (sys_rst),
        .ui_clk_sync_rst     (ui_clk_sync_rst),
        .init_calib_complete (init_calib_complete),
        .app_addr            (app_addr),
        .app_cmd             (app_cmd),
        .app_en              (app_en),
        .app_rdy             (app_rdy),
        .app_wdf_data        (app_wdf_data),
        .app_wdf_wren        (app_wdf_wren),
        .app_wdf_end         (app_wdf_end),
        .app_wdf_mask        (app_wdf_mask),
        .app_wdf_rdy         (app_wdf_rdy),
        .app_rd_data         (app_rd_data),
        .app_rd_data_valid   (app_rd_data_valid),
        .app_rd_data_end     (app_rd_data_end),
        .err_cmd             (err_cmd)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [MASK_W-1:0] mask;
        logic [DATA_W-1:0] exp;
    } vec_t;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int stall_cnt = 0;
    logic [DATA_W-1:0] got_q[$];
    logic [DATA_W-1:0] exp_q[$];
    int                vcyc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (app_rd_data_valid) begin
            got_q.push_back(app_rd_data);
            vcyc_q.push_back(cyc);
            if (app_rd_data_end !== 1'b1) begin
                errors = errors + 1;
                $display("FAIL rd_end: got %b required 1", app_rd_data_end);
            end
        end
    end

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL %s: handshake timed out", name);
    endtask

    task automatic issue_cmd(input logic [2:0] c, input logic [ADDR_W-1:0] a, output int acc);
        int n = 0;
        app_cmd = c; app_addr = a; app_en = 1'b1;
        while (!app_rdy && n < 100) begin
            @(negedge clk); n++;
        end
        stall_cnt += n;
        acc = -1;
        if (n >= 100) timeout("cmd_timeout");
        else begin
            @(posedge clk); @(negedge clk);
            acc = cyc;
        end
        app_en = 1'b0;
    endtask

    task automatic issue_wdf(input logic [DATA_W-1:0] d, input logic [MASK_W-1:0] m);
        int n = 0;
        app_wdf_data = d; app_wdf_mask = m; app_wdf_wren = 1'b1; app_wdf_end = 1'b1;
        while (!app_wdf_rdy && n < 100) begin
            @(negedge clk); n++;
        end
        if (n >= 100) timeout("wdf_timeout");
        else begin
            @(posedge clk); @(negedge clk);
        end
        app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
    endtask

    task automatic issue_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                               input logic [MASK_W-1:0] m);
        logic c, w;
        int n = 0;
        app_cmd = 3'b000; app_addr = a; app_en = 1'b1;
        app_wdf_data = d; app_wdf_mask = m; app_wdf_wren = 1'b1; app_wdf_end = 1'b1;
        while ((app_en || app_wdf_wren) && n < 100) begin
            c = app_en && app_rdy;
            w = app_wdf_wren && app_wdf_rdy;
            if (app_en && !app_rdy) stall_cnt++;
            @(posedge clk); @(negedge clk);
            if (c) app_en = 1'b0;
            if (w) begin app_wdf_wren = 1'b0; app_wdf_end = 1'b0; end
            n++;
        end
        if (n >= 100) timeout("write_timeout");
        app_en = 1'b0; app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
    endtask

    task automatic read_exp(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] e);
        int acc;
        issue_cmd(3'b001, a, acc);
        exp_q.push_back(e);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (got_q.size() < exp_q.size() && n < 300) begin
            @(negedge clk); n++;
        end
        repeat (8) @(negedge clk);
        chk({name, "_count"}, DATA_W'(got_q.size()), DATA_W'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_beat%0d", name, i), got_q[i], exp_q[i]);
        got_q.delete(); exp_q.delete(); vcyc_q.delete();
    endtask

    task automatic wait_calib(output int m);
        m = 0;
        while (!init_calib_complete && m < 60) begin
            @(posedge clk); #1; m++;
        end
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t tbl[12];
        logic [DATA_W-1:0] ones;
        logic [DATA_W-1:0] a_v [3];
        logic [DATA_W-1:0] b_v [3];
        int n, m, acc, acc0, rdy_hi;
        logic seen;

        ones = '1;
        for (int i = 0; i < 10; i++) begin
            tbl[i].addr = ADDR_W'(i * 8);
            tbl[i].data = DATA_W'(i * 2);
            tbl[i].mask = 32'h0000_0000;
            tbl[i].exp  = DATA_W'(i * 2);
        end
        tbl[10] = '{addr: 29'd0, data: ones, mask: 32'h0000_0000, exp: ones};
        tbl[11] = '{addr: 29'd0, data: 256'd0, mask: 32'h0000_FFFF,
                    exp: {128'd0, ones[127:0]}};

        sys_rst = 1'b0; app_en = 1'b0; app_cmd = 3'b000; app_addr = '0;
        app_wdf_data = '0; app_wdf_wren = 1'b0; app_wdf_end = 1'b0; app_wdf_mask = '0;

        // reset state and calibration sequence
        repeat (3) @(negedge clk);
        chk("rst_sync_rst", DATA_W'(ui_clk_sync_rst), 256'd1);
        chk("rst_calib", DATA_W'(init_calib_complete), 256'd0);
        chk("rst_outputs", DATA_W'({app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data_end, err_cmd}), 256'd0);
        chk("rst_rd_data", app_rd_data, 256'd0);
        sys_rst = 1'b1;
        n = 0;
        while (ui_clk_sync_rst && n < 10) begin
            @(posedge clk); #1; n++;
        end
        chk("sync_rst_edges", DATA_W'(n), 256'd2);
        m = 0; seen = 1'b0;
        while (!init_calib_complete && m < 60) begin
            if (app_rdy || app_wdf_rdy) seen = 1'b1;
            @(posedge clk); #1; m++;
        end
        chk("calib_edges", DATA_W'(m), 256'd16);
        chk("rdy_before_calib", DATA_W'(seen), 256'd0);
        @(negedge clk);

        // ten paired writes, then ten reads in order
        for (int i = 0; i < 10; i++) issue_write(tbl[i].addr, tbl[i].data, tbl[i].mask);
        repeat (5) @(negedge clk);
        acc0 = -1;
        for (int i = 0; i < 10; i++) begin
            issue_cmd(3'b001, tbl[i].addr, acc);
            if (i == 0) acc0 = acc;
            exp_q.push_back(tbl[i].exp);
        end
        repeat (10) @(negedge clk);
        chk("rd_latency", DATA_W'((vcyc_q.size() > 0) ? vcyc_q[0] - acc0 : -1), 256'd5);
        drain("burst10");

        // byte mask
        issue_write(tbl[10].addr, tbl[10].data, tbl[10].mask);
        issue_write(tbl[11].addr, tbl[11].data, tbl[11].mask);
        read_exp(29'd0, tbl[11].exp);
        drain("mask");

        // data before commands, then commands before data with a read queued behind
        for (int i = 0; i < 3; i++) begin
            a_v[i] = {8{32'hA000_0000 + 32'(i)}};
            b_v[i] = {8{32'hB000_0000 + 32'(i)}};
        end
        for (int i = 0; i < 3; i++) issue_wdf(a_v[i], 32'h0);
        issue_cmd(3'b000, 29'd16, acc);
        issue_cmd(3'b000, 29'd24, acc);
        issue_cmd(3'b000, 29'd32, acc);
        repeat (3) @(negedge clk);
        issue_cmd(3'b000, 29'd8, acc);
        issue_cmd(3'b000, 29'd48, acc);
        issue_cmd(3'b000, 29'd56, acc);
        read_exp(29'd8, b_v[0]);
        for (int i = 0; i < 3; i++) issue_wdf(b_v[i], 32'h0);
        read_exp(29'd16, a_v[0]);
        read_exp(29'd24, a_v[1]);
        read_exp(29'd32, a_v[2]);
        read_exp(29'd48, b_v[1]);
        read_exp(29'd56, b_v[2]);
        drain("order");

        // throttled stream of twenty writes, including an aliased read-back
        stall_cnt = 0;
        for (int i = 0; i < 20; i++) issue_write(ADDR_W'((20 + i) * 8), DATA_W'(32'h1000 + i), 32'h0);
        chk("throttle_seen", DATA_W'(stall_cnt > 0), 256'd1);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 20; i++) read_exp(ADDR_W'((20 + i) * 8), DATA_W'(32'h1000 + i));
        read_exp(ADDR_W'((64 + 20) * 8 + 5), DATA_W'(32'h1000));
        drain("throttle");

        // command queue full while data is withheld
        for (int i = 0; i < 4; i++) issue_cmd(3'b000, ADDR_W'((60 + i) * 8), acc);
        rdy_hi = 0;
        for (int i = 0; i < 6; i++) begin
            if (app_rdy) rdy_hi++;
            @(negedge clk);
        end
        chk("cmdq_full_rdy", DATA_W'(rdy_hi), 256'd0);
        chk("cmdq_full_wdf_rdy", DATA_W'(app_wdf_rdy), 256'd1);
        for (int i = 0; i < 4; i++) issue_wdf(DATA_W'(32'h6000 + i), 32'h0);
        for (int i = 0; i < 4; i++) read_exp(ADDR_W'((60 + i) * 8), DATA_W'(32'h6000 + i));
        drain("full");

        // invalid command
        chk("err_before", DATA_W'(err_cmd), 256'd0);
        issue_cmd(3'b010, 29'd0, acc);
        repeat (10) @(negedge clk);
        chk("err_set", DATA_W'(err_cmd), 256'd1);
        chk("err_no_rd", DATA_W'(got_q.size()), 256'd0);

        // reset in the middle of a read stream
        issue_cmd(3'b001, 29'd0, acc);
        issue_cmd(3'b001, 29'd8, acc);
        issue_cmd(3'b001, 29'd16, acc);
        sys_rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("midrst_no_rd", DATA_W'(got_q.size()), 256'd0);
        chk("midrst_state", DATA_W'({ui_clk_sync_rst, init_calib_complete, err_cmd, app_rdy}), 256'h8);
        sys_rst = 1'b1;
        wait_calib(m);
        chk("recalib", DATA_W'(init_calib_complete), 256'd1);
        chk("recalib_no_rd", DATA_W'(got_q.size()), 256'd0);
        chk("err_cleared", DATA_W'(err_cmd), 256'd0);
        read_exp(29'd0, tbl[11].exp);
        read_exp(29'd8, b_v[0]);
        read_exp(29'd160, DATA_W'(32'h1000));
        drain("retained");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
